// File: rtl/rast_perf_mon_if.sv
// Dump readout channel of the rasterizer performance monitor.
//   dump_req   : consumer requests a serial readout of every counter
//   dump_ready : consumer accepts the word on dump_data this cycle
//   dump_valid : dump_data/dump_idx/dump_last are valid
//   dump_data  : counter value (CNT_W bits)
//   dump_idx   : index of the counter currently on dump_data (IDX_W bits)
//   dump_last  : high with the final counter of the readout
// master = monitor side, slave = consumer side.
interface rast_perf_mon_if #(
  parameter int CNT_W = 32,
  parameter int IDX_W = 3
);
  logic             dump_req;
  logic             dump_ready;
  logic             dump_valid;
  logic [CNT_W-1:0] dump_data;
  logic [IDX_W-1:0] dump_idx;
  logic             dump_last;

  modport master (
    input  dump_req, dump_ready,
    output dump_valid, dump_data, dump_idx, dump_last
  );

  modport slave (
    output dump_req, dump_ready,
    input  dump_valid, dump_data, dump_idx, dump_last
  );
endinterface

// File: rtl/rast_perf_mon.sv
// Rasterizer performance monitor: counts run cycles, accepted triangles,
// stall cycles, sample tests and per-lane hits, then reads the counters out
// one word at a time over a valid/ready channel.
// Counter map: 0 run cycles, 1 triangles, 2 stall cycles, 3 samples,
// 4+k hits on lane k.
// Ports:
//   clk             clock, rising edge
//   rst             asynchronous reset, active low
//   validTri_R10H   triangle offered
//   halt_RnnnnL     low = pipeline stalled
//   validSamp_R16H  sample test issued
//   hit_valid_R18H  per-lane hit strobes [LANES]
//   start / stop    clear+begin counting / end counting
//   dmp             dump channel (rast_perf_mon_if.master)
//   busy            high while counting or dumping
//   overflow        sticky, set once any counter has reached all-ones
// Build option: RAST_PERF_MON_SATURATE_EN makes counters stick at all-ones
// instead of wrapping to zero.
module rast_perf_mon #(
  parameter int LANES = 2,
  parameter int CNT_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                validTri_R10H,
  input  logic                halt_RnnnnL,
  input  logic                validSamp_R16H,
  input  logic [LANES-1:0]    hit_valid_R18H,
  input  logic                start,
  input  logic                stop,
  rast_perf_mon_if.master     dmp,
  output logic                busy,
  output logic                overflow
);
  localparam int NCNT  = 4 + LANES;
  localparam int IDX_W = $clog2(NCNT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCNT - 1);

  typedef enum logic [1:0] {IDLE, RUN, FROZEN, DUMP} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] dump_idx_r, idx_nxt;
  logic             clr;
  logic [NCNT-1:0]  ev;
  logic             any_ones;
  logic [CNT_W-1:0] cnt [NCNT];

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
`ifdef RAST_PERF_MON_SATURATE_EN
    return (&v) ? v : v + CNT_W'(1);
`else
    return v + CNT_W'(1);
`endif
  endfunction

  // Event strobes in counter-index order.
  always_comb begin
    ev    = '0;
    ev[0] = 1'b1;
    ev[1] = validTri_R10H & halt_RnnnnL;
    ev[2] = ~halt_RnnnnL;
    ev[3] = validSamp_R16H;
    for (int k = 0; k < LANES; k++) ev[4+k] = hit_valid_R18H[k];
  end

  always_comb begin
    any_ones = 1'b0;
    for (int i = 0; i < NCNT; i++) any_ones = any_ones | (&cnt[i]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      dump_idx_r <= '0;
    end else begin
      state      <= state_nxt;
      dump_idx_r <= idx_nxt;
    end
  end

  // Start has priority over dump_req when idle/frozen; in RUN only stop is
  // honoured, and DUMP only reacts to the consumer handshake.
  always_comb begin
    state_nxt = state;
    idx_nxt   = dump_idx_r;
    clr       = 1'b0;
    unique case (state)
      IDLE, FROZEN: begin
        if (start) begin
          clr       = 1'b1;
          state_nxt = RUN;
        end else if (dmp.dump_req) begin
          state_nxt = DUMP;
          idx_nxt   = '0;
        end
      end
      RUN: begin
        if (stop) state_nxt = FROZEN;
      end
      DUMP: begin
        if (dmp.dump_ready) begin
          if (dump_idx_r == LAST_IDX) begin
            state_nxt = FROZEN;
            idx_nxt   = '0;
          end else begin
            idx_nxt = dump_idx_r + IDX_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NCNT; i++) cnt[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < NCNT; i++) cnt[i] <= '0;
    end else if (state == RUN) begin
      for (int i = 0; i < NCNT; i++)
        if (ev[i]) cnt[i] <= cnt_inc(cnt[i]);
    end
  end

  // Registered from the current counter values, so it rises the cycle after
  // a counter reaches all-ones and stays set even if that counter wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          overflow <= 1'b0;
    else if (clr)      overflow <= 1'b0;
    else if (any_ones) overflow <= 1'b1;
  end

  always_comb begin
    dmp.dump_data = '0;
    for (int i = 0; i < NCNT; i++)
      if (dump_idx_r == IDX_W'(i)) dmp.dump_data = cnt[i];
  end

  assign dmp.dump_valid = (state == DUMP);
  assign dmp.dump_idx   = dump_idx_r;
  assign dmp.dump_last  = (state == DUMP) && (dump_idx_r == LAST_IDX);
  assign busy           = (state == RUN) || (state == DUMP);
endmodule
